ram_sp_be_clr: RTL
==================

// Module: ram_sp_be_clr
//
// PURPOSE
//   Parametrised single-port synchronous RAM. Successor to the fixed 2^16x32 data RAM.
//   - Configurable width and depth; per-byte write enables.
//   - Registered read with a read_valid strobe.
//   - Hardware clear sequencer that zeroes every word after reset.
//   - Out-of-range address detection.
//   Sits on the CPU data-memory path. Also reused as instruction/scratch memory via parameters.
//
// PARAMETERS
//   DATA_W   32      word width in bits; must be a multiple of 8
//   ADDR_W   16      address port width
//   DEPTH    65536   number of words; 1 <= DEPTH <= 2**ADDR_W
//   BE_W     DATA_W/8  derived localparam, not overridable; byte-enable width
//
// PORTS
//   clk           in   1        rising-edge clock
//   rst           in   1        synchronous reset, active-high
//   write_enable  in   1        write request this cycle
//   read_enable   in   1        read request this cycle
//   address       in   ADDR_W   word address for read/write
//   data_input    in   DATA_W   write data
//   byte_enable   in   BE_W     bit i enables data_input[8i+7:8i]
//   data_output   out  DATA_W   registered read data
//   read_valid    out  1        1-cycle strobe: data_output updated by a read
//   addr_err      out  1        1-cycle strobe: accepted access had address >= DEPTH
//   busy          out  1        clear sequence running; requests ignored
//
// BEHAVIOUR
//   Reset (rst=1 at posedge)
//   - Register state: data_output=0, read_valid=0, addr_err=0, busy=1, FSM=CLEAR, clr_addr=0.
//   - Array contents are untouched by reset itself.
//   FSM CLEAR
//   - Each cycle: mem[clr_addr] <= 0 and clr_addr increments.
//   - On the cycle clr_addr==DEPTH-1, that word is written, then FSM goes to IDLE.
//   - busy stays 1 for exactly DEPTH cycles after the first posedge with rst=0; it is 0 from the next cycle.
//   - While busy, write_enable/read_enable are ignored: no array write, read_valid=0, addr_err=0.
//   - rst asserted mid-clear restarts the sequence from clr_addr=0.
//   FSM IDLE (busy=0) — an access is accepted when its enable is 1.
//   - Write: mem[address] byte i <= data_input byte i for every byte_enable[i]=1; other bytes keep their value.
//     byte_enable=0 means no change to the array.
//   - Read: latency 1. On the next cycle data_output=mem[address] and read_valid=1.
//   - Read and write to the same address in one cycle: read-first. data_output returns the pre-write word;
//     the write still commits.
//   - No read accepted: data_output holds its last value and read_valid=0.
//   - Address >= DEPTH on an accepted access: the write is dropped. On the next cycle addr_err=1; if it was a read,
//     data_output=0 and read_valid=1. Addresses never wrap or alias.
//   - addr_err and read_valid are single-cycle strobes, re-evaluated every cycle.
//   - No combinational path from any input to any output.
//
// TESTING (bench overrides DEPTH=16, ADDR_W=16, DATA_W=32)
//   1. Pulse rst 1 cycle -> busy=1 for exactly 16 cycles, then 0. A read of each addr 0..15 returns 0 with read_valid=1.
//   2. Write addr 5 = 32'hDEADBEEF, be=4'hF; next cycle read addr 5
//      -> following cycle data_output=32'hDEADBEEF, read_valid=1.
//   3. Write addr 5 = 32'h11223344 with be=4'b0101, then read addr 5 -> data_output=32'hDE22BE44.
//   4. Same cycle: write addr 7 = 20, be=4'hF, and read addr 7 (prior value 0)
//      -> data_output=0. A following read of addr 7 returns 20.
//   5. Write addr 20 = 32'hFFFF_FFFF -> addr_err=1 for 1 cycle, array unchanged.
//      Read addr 20 -> data_output=0, read_valid=1, addr_err=1.
//   6. Assert rst at clear cycle 8, hold 1 cycle -> busy stays 1 for 16 further cycles.
//      read_enable=1 throughout busy -> read_valid stays 0.

Source files
------------

// File: rtl/ram_sp_be_clr.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// After reset, a clear sequencer zeroes every word. Accesses to addresses >= DEPTH are flagged.
module ram_sp_be_clr #(
  parameter int   DATA_W = 32,
  parameter int   ADDR_W = 16,
  parameter int   DEPTH  = 65536,
  localparam int  BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_input,
  input  logic [BE_W-1:0]   byte_enable,
  output logic [DATA_W-1:0] data_output,
  output logic              read_valid,
  output logic              addr_err,
  output logic              busy
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  clr_addr_reg, clr_addr_next;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               in_range;
  logic               idle;
  logic               rd_accept;
  logic               any_accept;
  logic [IDX_W-1:0]   acc_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [BE_W-1:0]    wr_en;
  logic [DATA_W-1:0]  wr_data;

  // Range check on the full address so out-of-range words never alias into the array.
  assign in_range   = ({1'b0, address} < DEPTH_EXT);
  assign idle       = (state_reg == IDLE);
  assign rd_accept  = idle && read_enable;
  assign any_accept = idle && (read_enable || write_enable);
  assign acc_idx    = address[IDX_W-1:0];
  assign busy       = (state_reg == CLEAR);

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      CLEAR: begin
        clr_addr_next = clr_addr_reg + 1'b1;
        if (clr_addr_reg == LAST_ADDR) begin
          state_next    = IDLE;
          clr_addr_next = '0;
        end
      end
      IDLE: begin
        state_next = IDLE;
      end
      default: begin
        state_next    = CLEAR;
        clr_addr_next = '0;
      end
    endcase
  end

  // One shared write port: the clear sequencer owns it while busy, the user afterwards.
  always_comb begin
    wr_en   = '0;
    wr_idx  = acc_idx;
    wr_data = data_input;
    if (state_reg == CLEAR) begin
      wr_en   = '1;
      wr_idx  = clr_addr_reg[IDX_W-1:0];
      wr_data = '0;
    end else if (write_enable && in_range) begin
      wr_en = byte_enable;
    end
    if (rst) begin
      wr_en = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (wr_en[b]) begin
        mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Read sees the array before this cycle's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
      data_output  <= '0;
      read_valid   <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      read_valid   <= rd_accept;
      addr_err     <= any_accept && !in_range;
      if (rd_accept) begin
        data_output <= in_range ? mem[acc_idx] : '0;
      end
    end
  end

endmodule
